sprite_dma_ctrl: RTL and testbench

- Bus-master controller that shares the cpu6502 address/data bus between the CPU and a page-copy DMA engine.
- A CPU store to TRIGGER_ADDR starts the copy. Writing value P copies bytes $PP00..$PPFF to DEST_ADDR, one byte per read/write cycle pair.
- During the copy the CPU is stalled through cpu_rdy.
- The block sits between cpu6502 and the memory/ROM decode, and owns the muxed bus.

---
 rtl/cpu6502_bus_pkg.sv | 25 ++
 rtl/sprite_dma_ctrl_if.sv | 24 ++
 rtl/dma_bus_mux.sv | 41 ++++
 rtl/sprite_dma_ctrl.sv | 127 ++++++++++++
 tb/tb_sprite_dma_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu6502_bus_pkg.sv
// cpu6502_bus_pkg: shared types and constants for blocks that master the cpu6502 bus.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu6502_bus_pkg;

  // Bus ownership states of the page-copy DMA controller.
  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] TRIGGER_ADDR_DEF = 16'h4014;
  localparam logic [15:0] DEST_ADDR_DEF    = 16'h2004;

  // Bytes per copy; the source index is 8 bits, so the last index is $FF.
  localparam int          XFER_LEN   = 256;
  localparam logic [7:0]  LAST_INDEX = 8'(XFER_LEN - 1);

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/sprite_dma_ctrl_if.sv
// sprite_dma_ctrl_if: CPU-side request signals in, muxed memory-side bus out.
// Latency: n/a (wiring only).
// Backpressure: none on this bundle; CPU stalls travel on the separate cpu_rdy line.
interface sprite_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_rw;
  logic [7:0]  mem_idata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_odata;
  logic        bus_rw;

  // The bus owner sees the CPU request and memory data, and drives the memory bus.
  modport master (
    input  cpu_addr, cpu_odata, cpu_rw, mem_idata,
    output bus_addr, bus_odata, bus_rw
  );

  // The surrounding system drives CPU request and memory data, and observes the bus.
  modport slave (
    output cpu_addr, cpu_odata, cpu_rw, mem_idata,
    input  bus_addr, bus_odata, bus_rw
  );
endinterface

// File: rtl/dma_bus_mux.sv
// dma_bus_mux: selects CPU passthrough or DMA read/write onto the memory bus by state.
// Latency: combinational, zero cycles.
// Backpressure: none; the controller decides ownership.
module dma_bus_mux
  import cpu6502_bus_pkg::*;
#(
  parameter logic [15:0] DEST_ADDR = DEST_ADDR_DEF
) (
  input  dma_state_t  state,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  input  logic [7:0]  page,
  input  logic [7:0]  index,
  input  logic [7:0]  buffer,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_odata,
  output logic        bus_rw
);

  // CPU owns the bus except in the two copy states; HALT/ALIGN reads are harmless repeats.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_odata = cpu_odata;
    bus_rw    = cpu_rw;
    case (state)
      READ: begin
        bus_addr  = {page, index};
        bus_odata = 8'h00;
        bus_rw    = RW_READ;
      end
      WRITE: begin
        bus_addr  = DEST_ADDR;
        bus_odata = buffer;
        bus_rw    = RW_WRITE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sprite_dma_ctrl.sv
// sprite_dma_ctrl: shares the cpu6502 bus with a 256-byte page-copy engine started by a store to TRIGGER_ADDR.
// Latency: busy/rdy change one clk after the trigger; a copy spans 513 or 514 CPU bus cycles.
// Backpressure: holds the CPU off via cpu_rdy for the whole copy; memory is assumed always ready.
module sprite_dma_ctrl
  import cpu6502_bus_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = TRIGGER_ADDR_DEF,
  parameter logic [15:0] DEST_ADDR    = DEST_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cycle_en,
  sprite_dma_ctrl_if.master bus,
  output logic              cpu_rdy,
  output logic              dma_busy
);

  dma_state_t  state_q, state_d;
  logic [7:0]  page_q;
  logic [7:0]  index_q;
  logic [7:0]  buffer_q;
  logic        parity_q;
  logic        start;
  logic        finish;
  logic        load_buf;
  logic        inc_index;

  // State register; everything moves only on CPU bus-cycle boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath strobes. A trigger seen in HALT (pending CPU write) is ignored.
  // When the CPU parks on a read and the cycle is already odd, HALT goes straight to READ,
  // so the alignment cycle is only spent when needed (513 vs 514 cycles total).
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    finish    = 1'b0;
    load_buf  = 1'b0;
    inc_index = 1'b0;
    if (cycle_en) begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_rw == RW_WRITE && bus.cpu_addr == TRIGGER_ADDR) begin
            state_d = HALT;
            start   = 1'b1;
          end
        end
        HALT: begin
          if (bus.cpu_rw == RW_READ) state_d = parity_q ? READ : ALIGN;
        end
        ALIGN: begin
          if (parity_q) state_d = READ;
        end
        READ: begin
          load_buf = 1'b1;
          state_d  = WRITE;
        end
        WRITE: begin
          if (index_q == LAST_INDEX) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            inc_index = 1'b1;
            state_d   = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Odd/even CPU cycle marker so every READ lands on an even cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         parity_q <= 1'b0;
    else if (cycle_en) parity_q <= ~parity_q;
  end

  // Source page/index and the one-byte holding buffer; index wraps within the page.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      buffer_q <= 8'h00;
    end else begin
      if (start) begin
        page_q  <= bus.cpu_odata;
        index_q <= 8'h00;
      end else if (inc_index) begin
        index_q <= index_q + 8'd1;
      end
      if (load_buf) buffer_q <= bus.mem_idata;
    end
  end

  // Registered stall/busy flags: raised by the trigger, dropped with the final write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdy  <= 1'b1;
      dma_busy <= 1'b0;
    end else if (start) begin
      cpu_rdy  <= 1'b0;
      dma_busy <= 1'b1;
    end else if (finish) begin
      cpu_rdy  <= 1'b1;
      dma_busy <= 1'b0;
    end
  end

  dma_bus_mux #(
    .DEST_ADDR (DEST_ADDR)
  ) u_mux (
    .state     (state_q),
    .cpu_addr  (bus.cpu_addr),
    .cpu_odata (bus.cpu_odata),
    .cpu_rw    (bus.cpu_rw),
    .page      (page_q),
    .index     (index_q),
    .buffer    (buffer_q),
    .bus_addr  (bus.bus_addr),
    .bus_odata (bus.bus_odata),
    .bus_rw    (bus.bus_rw)
  );

endmodule

// File: tb/tb_sprite_dma_ctrl.sv
// tb_sprite_dma_ctrl: directed bench for the sprite page-copy controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_sprite_dma_ctrl;

  localparam logic [15:0] TRIG   = 16'h4014;
  localparam logic [15:0] DEST   = 16'h2004;
  localparam logic [15:0] CPU_PC = 16'hC123;

  logic clk = 1'b0;
  logic reset;
  logic cycle_en;
  logic cpu_rdy;
  logic dma_busy;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  logic [15:0] s_addr;
  logic [7:0]  s_odata;
  logic        s_rw;
  logic        s_busy;
  logic        s_rdy;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[6];

  sprite_dma_ctrl_if ifc ();

  sprite_dma_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cycle_en (cycle_en),
    .bus      (ifc),
    .cpu_rdy  (cpu_rdy),
    .dma_busy (dma_busy)
  );

  // ROM image: every page holds index ^ $5A.
  assign ifc.mem_idata = ifc.bus_addr[7:0] ^ 8'h5A;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a CPU bus cycle and sample the bus just before its closing edge.
  task automatic cyc_sample(input logic [15:0] a, input logic [7:0] d, input logic rw);
    @(negedge clk);
    ifc.cpu_addr  = a;
    ifc.cpu_odata = d;
    ifc.cpu_rw    = rw;
    cycle_en      = 1'b0;
    @(negedge clk);
    cycle_en = 1'b1;
    s_addr  = ifc.bus_addr;
    s_odata = ifc.bus_odata;
    s_rw    = ifc.bus_rw;
    s_busy  = dma_busy;
    s_rdy   = cpu_rdy;
  endtask

  task automatic cyc_commit();
    @(posedge clk);
    #1;
    cycle_en = 1'b0;
    pulses++;
  endtask

  task automatic trigger(input logic [7:0] page, output int tp);
    tp = pulses % 2;
    cyc_sample(TRIG, page, 1'b0);
    check("trig_pass_addr", 32'(s_addr), 32'(TRIG));
    check("trig_busy_before", 32'(s_busy), 32'd0);
    cyc_commit();
    #2;
    check("trig_busy_after", 32'(dma_busy), 32'd1);
    check("trig_rdy_after", 32'(cpu_rdy), 32'd0);
  endtask

  // Run one copy after its trigger. nw pending CPU writes precede the first stalled read;
  // the last of them is a stray store to the trigger address. abort_idx >= 0 resets mid-WRITE.
  task automatic run_dma(input logic [7:0] page, input int nw, input int trig_par, input int abort_idx);
    int first_rd, busy_cnt, rd_idx, wr_idx, last_wr, exit_par, exp_first, exp_total;
    bit done, aborted;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    exit_par  = (trig_par + 1 + nw) % 2;
    exp_first = nw + ((exit_par == 1) ? 1 : 2);
    exp_total = exp_first + 512;
    first_rd = -1; busy_cnt = 0; rd_idx = 0; wr_idx = 0; last_wr = -1;
    done = 1'b0; aborted = 1'b0;
    for (int it = 1; it <= 700 && !done && !aborted; it++) begin
      if (it <= nw) begin
        a  = (it == nw) ? TRIG : 16'(16'h01FE - it);
        d  = 8'(8'h90 + it);
        rw = 1'b0;
      end else begin
        a  = CPU_PC;
        d  = 8'h00;
        rw = 1'b1;
      end
      cyc_sample(a, d, rw);
      if (it <= nw) begin
        check("halt_push_addr", 32'(s_addr), 32'(a));
        check("halt_push_data", 32'(s_odata), 32'(d));
        check("halt_push_rw", 32'(s_rw), 32'd0);
      end
      if (it == 1) check("stall_rdy", 32'(s_rdy), 32'd0);
      if (s_busy) begin
        busy_cnt++;
      end else begin
        done = 1'b1;
        check("done_after_last_write", 32'(it), 32'(last_wr + 1));
        check("resume_rdy", 32'(s_rdy), 32'd1);
        check("resume_addr", 32'(s_addr), 32'(CPU_PC));
      end
      if (s_busy && s_rw && s_addr != CPU_PC) begin
        if (first_rd < 0) first_rd = it - 1;
        check("rd_addr", 32'(s_addr), 32'({page, 8'(rd_idx)}));
        rd_idx++;
      end
      if (s_busy && !s_rw && s_addr == DEST) begin
        check("wr_data", 32'(s_odata), 32'(8'(wr_idx) ^ 8'h5A));
        last_wr = it;
        if (wr_idx == abort_idx) begin
          aborted = 1'b1;
          reset = 1'b1;
          #1;
          check("abort_rdy_async", 32'(cpu_rdy), 32'd1);
          check("abort_busy_async", 32'(dma_busy), 32'd0);
          @(posedge clk);
          #1;
          check("abort_rdy", 32'(cpu_rdy), 32'd1);
          check("abort_busy", 32'(dma_busy), 32'd0);
          check("abort_pass_addr", 32'(ifc.bus_addr), 32'(ifc.cpu_addr));
          @(negedge clk);
          cycle_en = 1'b0;
          reset    = 1'b0;
          pulses   = 0;
        end
        wr_idx++;
      end
      if (!aborted) cyc_commit();
    end
    if (aborted) begin
      check("abort_at_idx", 32'(wr_idx), 32'(abort_idx + 1));
    end else begin
      check("dma_finished", 32'(done), 32'd1);
      check("first_read_delay", 32'(first_rd), 32'(exp_first));
      check("busy_pulses", 32'(busy_cnt), 32'(exp_total));
      check("read_count", 32'(rd_idx), 32'd256);
      check("write_count", 32'(wr_idx), 32'd256);
    end
  endtask

  initial begin
    int tp, tp_first;
    reset         = 1'b1;
    cycle_en      = 1'b0;
    ifc.cpu_addr  = 16'h1234;
    ifc.cpu_odata = 8'h77;
    ifc.cpu_rw    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_bus_addr", 32'(ifc.bus_addr), 32'h1234);
    check("rst_bus_odata", 32'(ifc.bus_odata), 32'h77);
    check("rst_bus_rw", 32'(ifc.bus_rw), 32'd1);
    reset = 1'b0;

    // LDA #$02 fetches, near-miss stores/reads, then STA $4014.
    tbl[0] = '{16'hC000, 8'hA9, 1'b1, 1'b0};
    tbl[1] = '{16'hC001, 8'h02, 1'b1, 1'b0};
    tbl[2] = '{16'h4015, 8'h02, 1'b0, 1'b0};
    tbl[3] = '{16'h2004, 8'h55, 1'b0, 1'b0};
    tbl[4] = '{16'h4014, 8'h33, 1'b1, 1'b0};
    tbl[5] = '{16'h4014, 8'h02, 1'b0, 1'b1};
    tp_first = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) tp_first = pulses % 2;
      cyc_sample(tbl[i].a, tbl[i].d, tbl[i].rw);
      check("vec_bus_addr", 32'(s_addr), 32'(tbl[i].a));
      check("vec_bus_odata", 32'(s_odata), 32'(tbl[i].d));
      check("vec_bus_rw", 32'(s_rw), 32'(tbl[i].rw));
      check("vec_rdy_before", 32'(s_rdy), 32'd1);
      cyc_commit();
      #2;
      check("vec_busy_after", 32'(dma_busy), 32'(tbl[i].exp_busy));
      check("vec_rdy_after", 32'(cpu_rdy), 32'(!tbl[i].exp_busy));
    end
    run_dma(8'h02, 0, tp_first, -1);

    // Same copy triggered on the opposite parity.
    if (pulses % 2 == tp_first) cyc_sample(16'hC124, 8'h00, 1'b1);
    if (pulses % 2 == tp_first) cyc_commit();
    trigger(8'h02, tp);
    check("opposite_parity", 32'(tp), 32'(1 - tp_first));
    run_dma(8'h02, 0, tp, -1);

    // Top page: no wrap to $0000.
    trigger(8'hFF, tp);
    run_dma(8'hFF, 0, tp, -1);

    // Reset during WRITE of index $40, then a fresh copy from $0300.
    trigger(8'h03, tp);
    run_dma(8'h03, 0, tp, 8'h40);
    trigger(8'h03, tp);
    run_dma(8'h03, 0, tp, -1);

    // Interrupt push (3 writes) plus a stray trigger store while halted.
    trigger(8'h04, tp);
    run_dma(8'h04, 4, tp, -1);

    // Zero page copy with the other parity.
    if (pulses % 2 == tp) cyc_sample(16'hC124, 8'h00, 1'b1);
    if (pulses % 2 == tp) cyc_commit();
    trigger(8'h00, tp);
    run_dma(8'h00, 0, tp, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
